// File: rtl/imem_comp_pkg.sv
// Shared entry-format constants, load-select encodings, FSM states and the
// out-of-range fill word for the dictionary-compressed instruction memory.
// Also used by the offline compressor model to build code/dict/escape images.
package imem_comp_pkg;

  // Top bit of a code entry selects how the rest of the entry is interpreted.
  localparam logic TYPE_DICT = 1'b1;
  localparam logic TYPE_ESC  = 1'b0;

  // ld_sel encodings; the fourth encoding is reserved and writes nothing.
  localparam logic [1:0] LD_CODE = 2'd0;
  localparam logic [1:0] LD_DICT = 2'd1;
  localparam logic [1:0] LD_ESC  = 2'd2;

  // RV32 NOP returned for addresses beyond the code memory.
  localparam logic [31:0] OOR_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LOOKUP,
    ST_EXPAND,
    ST_RESP,
    ST_COOL
  } state_t;

  // Code entry width: one type bit plus the wider of the two index fields.
  function automatic int code_width(input int dict_bits, input int esc_aw);
    return 1 + ((dict_bits > esc_aw) ? dict_bits : esc_aw);
  endfunction

endpackage

// File: rtl/imem_dict_responder_if.sv
// Refill request/response and table-load signals between the instruction
// cache / loader (master) and the compressed memory responder (slave).
// mem_req_*: valid held until ready pulse; ld_*: strobe accepted when ld_ready.
interface imem_dict_responder_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic [31:0] mem_req_rdata;
  logic        ld_en;
  logic [1:0]  ld_sel;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;

  modport master (
    output mem_req_valid, mem_req_addr, ld_en, ld_sel, ld_addr, ld_data,
    input  mem_req_ready, mem_req_rdata, ld_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, ld_en, ld_sel, ld_addr, ld_data,
    output mem_req_ready, mem_req_rdata, ld_ready
  );
endinterface

// File: rtl/imem_dict_expand.sv
// Dictionary + escape tables with write ports and a registered expand stage.
// Latency: word_o updates one cycle after expand_en_i, then holds its value.
// No backpressure: writes and expands are accepted whenever strobed.
// Ports: clk/resetn; dict_we_i/dict_waddr_i, esc_we_i/esc_waddr_i, wdata_i
// (table writes); expand_en_i, entry_i, oor_i (expand request); word_o.
module imem_dict_expand
  import imem_comp_pkg::*;
#(
  parameter int          DICT_BITS = 8,
  parameter int          ESC_AW    = 8,
  parameter logic [31:0] OOR_WORD  = imem_comp_pkg::OOR_WORD
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     dict_we_i,
  input  logic [DICT_BITS-1:0]                     dict_waddr_i,
  input  logic                                     esc_we_i,
  input  logic [ESC_AW-1:0]                        esc_waddr_i,
  input  logic [31:0]                              wdata_i,
  input  logic                                     expand_en_i,
  input  logic [code_width(DICT_BITS, ESC_AW)-1:0] entry_i,
  input  logic                                     oor_i,
  output logic [31:0]                              word_o
);

  localparam int CW = code_width(DICT_BITS, ESC_AW);

  logic [31:0] dict_mem [2**DICT_BITS];
  logic [31:0] esc_mem  [2**ESC_AW];
  logic [31:0] word_q;

  // Table contents survive reset, so the arrays have no reset branch.
  always_ff @(posedge clk) begin
    if (dict_we_i) dict_mem[dict_waddr_i] <= wdata_i;
    if (esc_we_i)  esc_mem[esc_waddr_i]   <= wdata_i;
  end

  // Escape indices only use the low ESC_AW bits, so oversized indices wrap.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      word_q <= '0;
    end else if (expand_en_i) begin
      if (oor_i)                       word_q <= OOR_WORD;
      else if (entry_i[CW-1] == TYPE_DICT) word_q <= dict_mem[entry_i[DICT_BITS-1:0]];
      else                             word_q <= esc_mem[entry_i[ESC_AW-1:0]];
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/imem_dict_responder.sv
// Instruction-refill responder expanding dictionary-compressed code words.
// Latency: request accepted in IDLE at cycle N -> ready pulse at N+3+WAIT_CYCLES.
// Backpressure: one request in flight; loads accepted only in IDLE (ld_ready).
// Ports: clk, resetn (sync, active-low); bus_if (slave: refill handshake and
// table-load port); dict_hits/esc_hits (served-request counters).
module imem_dict_responder
  import imem_comp_pkg::*;
#(
  parameter int          CODE_AW     = 10,
  parameter int          DICT_BITS   = 8,
  parameter int          ESC_AW      = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] OOR_WORD    = imem_comp_pkg::OOR_WORD
) (
  input  logic                 clk,
  input  logic                 resetn,
  imem_dict_responder_if.slave bus_if,
  output logic [31:0]          dict_hits,
  output logic [31:0]          esc_hits
);

  localparam int CW = code_width(DICT_BITS, ESC_AW);
  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);

  logic [CW-1:0]      code_mem [2**CODE_AW];

  state_t             state_q;
  logic [WW-1:0]      wait_cnt_q;
  logic [CODE_AW-1:0] idx_q;
  logic               oor_q;
  logic [CW-1:0]      entry_q;
  logic               ready_q;
  logic               ld_ready_q;
  logic [31:0]        dict_hits_q;
  logic [31:0]        esc_hits_q;
  logic [31:0]        dict_hits_d;
  logic [31:0]        esc_hits_d;

  logic               ld_ok;
  logic               code_we;
  logic               dict_we;
  logic               esc_we;
  logic               req_oor;
  logic [31:0]        expanded_word;
  logic               unused_bits;

  // A pending refill takes priority over a load in the same IDLE cycle.
  assign ld_ok   = resetn && (state_q == ST_IDLE) && !bus_if.mem_req_valid && bus_if.ld_en;
  assign code_we = ld_ok && (bus_if.ld_sel == LD_CODE);
  assign dict_we = ld_ok && (bus_if.ld_sel == LD_DICT);
  assign esc_we  = ld_ok && (bus_if.ld_sel == LD_ESC);

  assign req_oor = |bus_if.mem_req_addr[31:CODE_AW+2];

  assign dict_hits_d = dict_hits_q + 32'd1;
  assign esc_hits_d  = esc_hits_q + 32'd1;

  // Byte-offset bits and high load-address bits are intentionally ignored.
  assign unused_bits = ^{bus_if.mem_req_addr[1:0], bus_if.ld_addr[15:CODE_AW]};

  always_ff @(posedge clk) begin
    if (code_we) code_mem[bus_if.ld_addr[CODE_AW-1:0]] <= bus_if.ld_data[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      idx_q       <= '0;
      oor_q       <= 1'b0;
      entry_q     <= '0;
      ready_q     <= 1'b0;
      ld_ready_q  <= 1'b1;
      dict_hits_q <= '0;
      esc_hits_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_if.mem_req_valid) begin
            idx_q      <= bus_if.mem_req_addr[CODE_AW+1:2];
            oor_q      <= req_oor;
            wait_cnt_q <= '0;
            ld_ready_q <= 1'b0;
            state_q    <= (WAIT_CYCLES == 0) ? ST_LOOKUP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) state_q <= ST_LOOKUP;
          else                         wait_cnt_q <= wait_cnt_q + 1'b1;
        end
        ST_LOOKUP: begin
          entry_q <= code_mem[idx_q];
          state_q <= ST_EXPAND;
        end
        ST_EXPAND: begin
          // The expand sub-module registers the word on this same edge,
          // so ready and rdata appear together in RESP.
          ready_q <= 1'b1;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          ready_q <= 1'b0;
          if (!oor_q) begin
            if (entry_q[CW-1] == TYPE_DICT) dict_hits_q <= dict_hits_d;
            else                            esc_hits_q  <= esc_hits_d;
          end
          state_q <= ST_COOL;
        end
        ST_COOL: begin
          // The cache still holds valid here; it must not start a new request.
          ld_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: begin
          ready_q    <= 1'b0;
          ld_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  imem_dict_expand #(
    .DICT_BITS (DICT_BITS),
    .ESC_AW    (ESC_AW),
    .OOR_WORD  (OOR_WORD)
  ) u_expand (
    .clk          (clk),
    .resetn       (resetn),
    .dict_we_i    (dict_we),
    .dict_waddr_i (bus_if.ld_addr[DICT_BITS-1:0]),
    .esc_we_i     (esc_we),
    .esc_waddr_i  (bus_if.ld_addr[ESC_AW-1:0]),
    .wdata_i      (bus_if.ld_data),
    .expand_en_i  (state_q == ST_EXPAND),
    .entry_i      (entry_q),
    .oor_i        (oor_q),
    .word_o       (expanded_word)
  );

  assign bus_if.mem_req_ready = ready_q;
  assign bus_if.mem_req_rdata = expanded_word;
  assign bus_if.ld_ready      = ld_ready_q;
  assign dict_hits            = dict_hits_q;
  assign esc_hits             = esc_hits_q;

endmodule

// File: tb/tb_imem_dict_responder.sv
// Bench for imem_dict_responder: directed vector table plus randomized
// requests against a table-level model of the compressed program.
module tb_imem_dict_responder;
  import imem_comp_pkg::*;

  localparam int WAIT_CYCLES = 2;
  localparam int LAT = 3 + WAIT_CYCLES;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] dict_hits;
  logic [31:0] esc_hits;

  imem_dict_responder_if bus_if();

  imem_dict_responder #(
    .CODE_AW(10), .DICT_BITS(8), .ESC_AW(8),
    .WAIT_CYCLES(WAIT_CYCLES), .OOR_WORD(32'h0000_0013)
  ) dut (
    .clk(clk), .resetn(resetn), .bus_if(bus_if),
    .dict_hits(dict_hits), .esc_hits(esc_hits)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model of the program image: entry = 9 bits, >=256 means dictionary.
  logic [8:0]  m_code [1024];
  logic [31:0] m_dict [256];
  logic [31:0] m_esc  [256];
  int unsigned m_dict_hits = 0;
  int unsigned m_esc_hits  = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_rdata;
    int          kind;   // 0 out of range, 1 dictionary, 2 escape
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a, output int kind);
    int unsigned widx = a / 4;
    logic [8:0] e;
    if (widx >= 1024) begin
      kind = 0;
      return 32'h0000_0013;
    end
    e = m_code[widx[9:0]];
    if (e >= 9'd256) begin
      kind = 1;
      return m_dict[8'(e - 9'd256)];
    end
    kind = 2;
    return m_esc[8'(e)];
  endfunction

  task automatic load(input logic [1:0] sel, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.ld_en = 1'b1; bus_if.ld_sel = sel; bus_if.ld_addr = a; bus_if.ld_data = d;
    @(negedge clk);
    bus_if.ld_en = 1'b0;
    case (sel)
      2'd0: m_code[a % 1024] = d[8:0];
      2'd1: m_dict[a % 256]  = d;
      2'd2: m_esc[a % 256]   = d;
      default: ;
    endcase
  endtask

  task automatic start_req(input logic [31:0] a);
    @(negedge clk);
    bus_if.mem_req_valid = 1'b1;
    bus_if.mem_req_addr  = a;
  endtask

  // Waits (bounded) for the ready pulse, checks latency/data, then the COOL cycle.
  task automatic finish_req(input string tag, input logic [31:0] exp, input int kind, input int already);
    int cnt = already;
    bit seen = 0;
    while (!seen && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (bus_if.mem_req_ready) seen = 1;
    end
    check({tag, " latency"}, 32'(cnt), 32'(LAT));
    check({tag, " rdata"}, bus_if.mem_req_rdata, exp);
    bus_if.mem_req_valid = 1'b0;
    if (kind == 1) m_dict_hits++;
    else if (kind == 2) m_esc_hits++;
    @(negedge clk);
    check({tag, " cool ready"}, {31'b0, bus_if.mem_req_ready}, 32'd0);
    check({tag, " rdata hold"}, bus_if.mem_req_rdata, exp);
    check({tag, " dict_hits"}, dict_hits, m_dict_hits);
    check({tag, " esc_hits"}, esc_hits, m_esc_hits);
  endtask

  task automatic do_req(input string tag, input logic [31:0] a);
    int kind;
    logic [31:0] exp;
    exp = model_word(a, kind);
    start_req(a);
    finish_req(tag, exp, kind, 0);
  endtask

  initial begin
    int cnt, k0, k1, rdy_cnt;
    bit seen;
    logic [31:0] e0, e1, a, exp;
    int kind;

    resetn = 1'b0;
    bus_if.mem_req_valid = 1'b0; bus_if.mem_req_addr = '0;
    bus_if.ld_en = 1'b0; bus_if.ld_sel = '0; bus_if.ld_addr = '0; bus_if.ld_data = '0;
    repeat (3) @(negedge clk);
    check("reset ready", {31'b0, bus_if.mem_req_ready}, 32'd0);
    check("reset rdata", bus_if.mem_req_rdata, 32'd0);
    check("reset ld_ready", {31'b0, bus_if.ld_ready}, 32'd1);
    check("reset dict_hits", dict_hits, 32'd0);
    check("reset esc_hits", esc_hits, 32'd0);
    resetn = 1'b1;

    // Random background image so every entry is defined.
    for (int i = 0; i < 1024; i++) load(LD_CODE, 16'(i), $urandom);
    for (int i = 0; i < 256; i++) load(LD_DICT, 16'(i), $urandom);
    for (int i = 0; i < 256; i++) load(LD_ESC, 16'(i), $urandom);

    // Directed image entries.
    load(LD_DICT, 16'd5, 32'h0000_0013);
    load(LD_CODE, 16'd0, 32'h0000_0105);       // dict, index 5
    load(LD_ESC, 16'd3, 32'hDEAD_BEEF);
    load(LD_CODE, 16'd7, 32'h0000_0003);       // escape, index 3
    load(LD_ESC, 16'h0109, 32'h0BAD_F00D);     // high ld_addr bits ignored -> esc[9]
    load(LD_CODE, 16'd8, 32'h0000_0009);       // escape, index 9
    load(LD_ESC, 16'd5, 32'hCAFE_F00D);
    load(LD_CODE, 16'd9, 32'hFFFF_FE05);       // only low 9 bits kept -> escape 5

    vecs[0] = '{32'h0000_0000, 32'h0000_0013, 1};
    vecs[1] = '{32'h0000_001C, 32'hDEAD_BEEF, 2};
    vecs[2] = '{32'h0000_1000, 32'h0000_0013, 0};
    vecs[3] = '{32'h0000_001F, 32'hDEAD_BEEF, 2};
    vecs[4] = '{32'h0000_0020, 32'h0BAD_F00D, 2};
    vecs[5] = '{32'h0000_0024, 32'hCAFE_F00D, 2};
    vecs[6] = '{32'h8000_0000, 32'h0000_0013, 0};
    for (int i = 0; i < 7; i++) begin
      start_req(vecs[i].addr);
      finish_req($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].kind, 0);
    end

    // Back-to-back with valid held high across the pulse and COOL.
    e0 = model_word(32'h0, k0);
    e1 = model_word(32'h4, k1);
    start_req(32'h0);
    cnt = 0; seen = 0;
    while (!seen && cnt < 40) begin
      @(negedge clk); cnt++;
      if (bus_if.mem_req_ready) seen = 1;
    end
    check("b2b first latency", 32'(cnt), 32'(LAT));
    check("b2b first rdata", bus_if.mem_req_rdata, e0);
    bus_if.mem_req_addr = 32'h4;
    if (k0 == 1) m_dict_hits++; else if (k0 == 2) m_esc_hits++;
    cnt = 0; seen = 0;
    while (!seen && cnt < 40) begin
      @(negedge clk); cnt++;
      if (bus_if.mem_req_ready) seen = 1;
    end
    check("b2b pulse gap", 32'(cnt), 32'(2 + LAT));
    check("b2b second rdata", bus_if.mem_req_rdata, e1);
    bus_if.mem_req_valid = 1'b0;
    if (k1 == 1) m_dict_hits++; else if (k1 == 2) m_esc_hits++;
    @(negedge clk);
    check("b2b cool ready", {31'b0, bus_if.mem_req_ready}, 32'd0);
    check("b2b dict_hits", dict_hits, m_dict_hits);
    check("b2b esc_hits", esc_hits, m_esc_hits);

    // Load attempted during LOOKUP is dropped.
    start_req(32'h0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    bus_if.ld_en = 1'b1; bus_if.ld_sel = LD_DICT; bus_if.ld_addr = 16'd5; bus_if.ld_data = 32'h1111_1111;
    check("lookup ld_ready", {31'b0, bus_if.ld_ready}, 32'd0);
    @(negedge clk);
    bus_if.ld_en = 1'b0;
    m_dict_hits++;
    finish_req("busy load", 32'h0000_0013, 0, 4);
    start_req(32'h0);
    finish_req("after dropped load", 32'h0000_0013, 1, 0);
    load(LD_DICT, 16'd5, 32'h1111_1111);
    start_req(32'h0);
    finish_req("idle load", 32'h1111_1111, 1, 0);
    load(2'd3, 16'd5, 32'h2222_2222);
    start_req(32'h0);
    finish_req("sel3 load", 32'h1111_1111, 1, 0);

    // Reset during WAIT: no pulse, counters clear, tables survive.
    start_req(32'h0);
    @(negedge clk);
    resetn = 1'b0;
    bus_if.mem_req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_dict_hits = 0; m_esc_hits = 0;
    rdy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_if.mem_req_ready) rdy_cnt++;
    end
    check("reset abort pulses", 32'(rdy_cnt), 32'd0);
    check("reset abort dict_hits", dict_hits, 32'd0);
    check("reset abort esc_hits", esc_hits, 32'd0);
    check("reset abort ld_ready", {31'b0, bus_if.ld_ready}, 32'd1);
    start_req(32'h0);
    finish_req("post reset", 32'h1111_1111, 1, 0);

    // Randomized traffic: mixed loads, in/out of range, early valid drop.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0)
        load(2'($urandom_range(0, 3)), 16'($urandom), $urandom);
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_1000;
      else                           a = {20'b0, 10'($urandom), 2'($urandom)};
      exp = model_word(a, kind);
      start_req(a);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus_if.mem_req_valid = 1'b0;
        bus_if.mem_req_addr  = $urandom;
        finish_req("rand drop", exp, kind, 1);
      end else begin
        finish_req("rand", exp, kind, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
